// File: rtl/debug_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_pkg
// Description : Shared definitions for the debug dump engine: FSM state
//               encoding, command byte codes, dump-section encoding and a
//               small width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEL     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // SEC_CK is the trailing checksum byte; it only occurs when the
    // checksum feature is compiled in.
    typedef enum logic [1:0] {
        SEC_PC = 2'd0,
        SEC_RB = 2'd1,
        SEC_DM = 2'd2,
        SEC_CK = 2'd3
    } section_t;

    localparam logic [7:0] CMD_PC   = 8'h70;  // 'p'
    localparam logic [7:0] CMD_REGS = 8'h72;  // 'r'
    localparam logic [7:0] CMD_MEM  = 8'h6D;  // 'm'
    localparam logic [7:0] CMD_ALL  = 8'h61;  // 'a'

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : debug_dump_pkg
`default_nettype wire

// File: rtl/debug_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : debug_word_serializer
// Description : Holds one captured word and hands it out one byte at a time,
//               least-significant byte first.
//   i_load    : capture i_word and the number of valid bytes i_nbytes
//   i_shift   : consume the current byte (o_byte) and advance to the next
//   o_byte    : byte currently at the head of the word
//   o_empty   : no bytes left to send
// Revision    : 1.0 - initial release
// ============================================================================
module debug_word_serializer #(
    parameter int BYTE   = 8,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic [CNT_W-1:0]  i_nbytes,
    input  logic              i_shift,
    output logic [BYTE-1:0]   o_byte,
    output logic              o_empty
);

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_count <= i_nbytes;
        end else if (i_shift) begin
            r_word <= r_word >> BYTE;
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_byte  = r_word[BYTE-1:0];
    assign o_empty = (r_count == '0);

endmodule : debug_word_serializer
`default_nettype wire

// File: rtl/debug_dump_engine.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_engine
// Description : Command-driven state dump for the debug path. A command byte
//               from the debug UART selects PC, register bank, data memory or
//               all three; the selected values are read through the debug
//               read ports and sent byte by byte, LSB first, over the
//               tx_start/tx_done handshake.
//   Ports     : i_rx_done/i_rx_data  command input
//               i_tx_done/o_tx_start/o_tx_data  transmit handshake
//               o_rb_* / i_rb_data   register-bank debug read port
//               o_dm_* / i_dm_data   data-memory debug read port
//               i_pc_value           current PC
//               o_busy               dump in progress
//               o_error              one-cycle pulse on an unknown command
//   Macro     : DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte of all
//               payload bytes after the last payload byte.
//   DATA_W and PC_W must be multiples of BYTE; RB_DEPTH <= 2**RB_ADDR and
//   DM_DEPTH <= 2**DM_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_engine
    import debug_dump_pkg::*;
#(
    parameter int BYTE     = 8,
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int RB_ADDR  = 5,
    parameter int RB_DEPTH = 32,
    parameter int DM_ADDR  = 7,
    parameter int DM_DEPTH = 128
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [BYTE-1:0]    i_rx_data,
    input  logic               i_tx_done,
    input  logic [PC_W-1:0]    i_pc_value,
    input  logic [DATA_W-1:0]  i_rb_data,
    input  logic [BYTE-1:0]    i_dm_data,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic               o_rb_enable,
    output logic               o_rb_read_enable,
    output logic [RB_ADDR-1:0] o_rb_addr,
    output logic               o_dm_enable,
    output logic               o_dm_read_enable,
    output logic [DM_ADDR-1:0] o_dm_addr,
    output logic               o_busy,
    output logic               o_error
);

    localparam int c_word_w = max_int(DATA_W, PC_W);
    localparam int c_cnt_w  = $clog2(c_word_w / BYTE + 1);

    localparam logic [c_cnt_w-1:0] c_rb_bytes = c_cnt_w'(DATA_W / BYTE);
    localparam logic [c_cnt_w-1:0] c_pc_bytes = c_cnt_w'(PC_W / BYTE);
    localparam logic [c_cnt_w-1:0] c_one_byte = c_cnt_w'(1);
    localparam logic [RB_ADDR-1:0] c_rb_last  = RB_ADDR'(RB_DEPTH - 1);
    localparam logic [DM_ADDR-1:0] c_dm_last  = DM_ADDR'(DM_DEPTH - 1);

`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam logic c_ck_en = 1'b1;
`else
    localparam logic c_ck_en = 1'b0;
`endif

    state_t              r_state;
    section_t            r_sec;
    logic                r_do_pc;
    logic                r_do_rb;
    logic                r_do_dm;
    logic                r_ck_sent;
    logic [BYTE-1:0]     r_csum;

    logic                w_cmd_pc;
    logic                w_cmd_rb;
    logic                w_cmd_dm;
    logic                w_cmd_valid;
    logic                w_sec_end;
    logic                w_more;
    logic                w_ser_load;
    logic [c_word_w-1:0] w_ser_word;
    logic [c_cnt_w-1:0]  w_ser_nbytes;
    logic                w_ser_shift;
    logic [BYTE-1:0]     w_ser_byte;
    logic                w_ser_empty;

    // Command decode: 'a' simply requests all three sections.
    assign w_cmd_pc    = (i_rx_data == BYTE'(CMD_PC))   || (i_rx_data == BYTE'(CMD_ALL));
    assign w_cmd_rb    = (i_rx_data == BYTE'(CMD_REGS)) || (i_rx_data == BYTE'(CMD_ALL));
    assign w_cmd_dm    = (i_rx_data == BYTE'(CMD_MEM))  || (i_rx_data == BYTE'(CMD_ALL));
    assign w_cmd_valid = w_cmd_pc || w_cmd_rb || w_cmd_dm;

    // Anything still to send after the current section finishes.
    assign w_more = r_do_pc || r_do_rb || r_do_dm || (c_ck_en && !r_ck_sent);

    always_comb begin
        w_sec_end = 1'b1;
        case (r_sec)
            SEC_RB:  w_sec_end = (o_rb_addr == c_rb_last);
            SEC_DM:  w_sec_end = (o_dm_addr == c_dm_last);
            default: w_sec_end = 1'b1;
        endcase
    end

    // Serializer load: PC and checksum are loaded straight from SEL, bank
    // and memory words in CAPTURE once the read data is valid.
    always_comb begin
        w_ser_load   = 1'b0;
        w_ser_word   = '0;
        w_ser_nbytes = '0;
        case (r_state)
            ST_SEL: begin
                if (r_do_pc) begin
                    w_ser_load   = 1'b1;
                    w_ser_word   = c_word_w'(i_pc_value);
                    w_ser_nbytes = c_pc_bytes;
                end else if (!r_do_rb && !r_do_dm && c_ck_en && !r_ck_sent) begin
                    w_ser_load   = 1'b1;
                    w_ser_word   = c_word_w'(r_csum);
                    w_ser_nbytes = c_one_byte;
                end
            end
            ST_CAPTURE: begin
                w_ser_load = 1'b1;
                if (r_sec == SEC_RB) begin
                    w_ser_word   = c_word_w'(i_rb_data);
                    w_ser_nbytes = c_rb_bytes;
                end else begin
                    w_ser_word   = c_word_w'(i_dm_data);
                    w_ser_nbytes = c_one_byte;
                end
            end
            default: ;
        endcase
    end

    assign w_ser_shift = (r_state == ST_SEND);

    debug_word_serializer #(
        .BYTE   (BYTE),
        .WORD_W (c_word_w),
        .CNT_W  (c_cnt_w)
    ) u_serializer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_load   (w_ser_load),
        .i_word   (w_ser_word),
        .i_nbytes (w_ser_nbytes),
        .i_shift  (w_ser_shift),
        .o_byte   (w_ser_byte),
        .o_empty  (w_ser_empty)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_sec            <= SEC_PC;
            r_do_pc          <= 1'b0;
            r_do_rb          <= 1'b0;
            r_do_dm          <= 1'b0;
            r_ck_sent        <= 1'b0;
            r_csum           <= '0;
            o_tx_data        <= '0;
            o_tx_start       <= 1'b0;
            o_rb_enable      <= 1'b0;
            o_rb_read_enable <= 1'b0;
            o_rb_addr        <= '0;
            o_dm_enable      <= 1'b0;
            o_dm_read_enable <= 1'b0;
            o_dm_addr        <= '0;
            o_busy           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            o_tx_start       <= 1'b0;
            o_error          <= 1'b0;
            o_rb_read_enable <= 1'b0;
            o_dm_read_enable <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A coincident tx_done wins over rx_done: the command
                    // byte is dropped.
                    if (i_rx_done && !i_tx_done) begin
                        if (w_cmd_valid) begin
                            r_do_pc   <= w_cmd_pc;
                            r_do_rb   <= w_cmd_rb;
                            r_do_dm   <= w_cmd_dm;
                            r_ck_sent <= 1'b0;
                            r_csum    <= '0;
                            o_busy    <= 1'b1;
                            r_state   <= ST_SEL;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end
                end

                ST_SEL: begin
                    if (r_do_pc) begin
                        r_do_pc <= 1'b0;
                        r_sec   <= SEC_PC;
                        r_state <= ST_SEND;
                    end else if (r_do_rb) begin
                        r_do_rb          <= 1'b0;
                        r_sec            <= SEC_RB;
                        o_rb_enable      <= 1'b1;
                        o_rb_addr        <= '0;
                        o_rb_read_enable <= 1'b1;
                        r_state          <= ST_FETCH;
                    end else if (r_do_dm) begin
                        r_do_dm          <= 1'b0;
                        r_sec            <= SEC_DM;
                        o_dm_enable      <= 1'b1;
                        o_dm_addr        <= '0;
                        o_dm_read_enable <= 1'b1;
                        r_state          <= ST_FETCH;
                    end else if (c_ck_en && !r_ck_sent) begin
                        r_ck_sent <= 1'b1;
                        r_sec     <= SEC_CK;
                        r_state   <= ST_SEND;
                    end else begin
                        o_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end

                // Read strobe was raised on entry; the read port returns
                // data one cycle later, i.e. during CAPTURE.
                ST_FETCH: r_state <= ST_CAPTURE;

                ST_CAPTURE: r_state <= ST_SEND;

                ST_SEND: begin
                    o_tx_data  <= w_ser_byte;
                    o_tx_start <= 1'b1;
                    if (r_sec != SEC_CK) begin
                        r_csum <= r_csum ^ w_ser_byte;
                    end
                    r_state <= ST_WAIT_TX;
                end

                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (!w_ser_empty) begin
                            r_state <= ST_SEND;
                        end else if (w_sec_end) begin
                            o_rb_enable <= 1'b0;
                            o_dm_enable <= 1'b0;
                            if (w_more) begin
                                r_state <= ST_SEL;
                            end else begin
                                // Drop busy immediately after the final
                                // tx_done rather than waiting for DONE.
                                o_busy  <= 1'b0;
                                r_state <= ST_DONE;
                            end
                        end else if (r_sec == SEC_RB) begin
                            o_rb_addr        <= o_rb_addr + 1'b1;
                            o_rb_read_enable <= 1'b1;
                            r_state          <= ST_FETCH;
                        end else begin
                            o_dm_addr        <= o_dm_addr + 1'b1;
                            o_dm_read_enable <= 1'b1;
                            r_state          <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : debug_dump_engine
`default_nettype wire
